// File: rtl/mempool_remote_link_arbiter.sv
// Remote link arbiter for the group egress port.
// Several tile-side remote requesters share one inter-group link.
// Requesters are picked round-robin, and a stalled grant is held until it completes.
// An ID FIFO sends in-order link responses back to the requester that issued
// each request, and it caps the number of requests in flight.

// Protocol checker. It is instantiated by the arbiter and watches its internal state.
module mempool_remote_link_arbiter_checker (
  input logic clk_i,
  input logic rst_ni,
  input logic lock_q_i,
  input logic lock_req_valid_i,
  input logic link_resp_valid_i,
  input logic fifo_empty_i
);

  // A locked requester must keep its valid asserted until the handshake completes.
  a_lock_hold_valid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    lock_q_i |-> lock_req_valid_i);

  // The link must not return a response when nothing is outstanding.
  a_no_orphan_resp: assert property (@(posedge clk_i) disable iff (!rst_ni)
    link_resp_valid_i |-> !fifo_empty_i);

endmodule

module mempool_remote_link_arbiter #(
  parameter int unsigned NumIn          = 4,
  parameter int unsigned MaxOutstanding = 8,
  // In the cluster these become tcdm_slave_req_t / tcdm_master_resp_t.
  parameter type         req_t          = logic [31:0],
  parameter type         resp_t         = logic [31:0],
  localparam int unsigned IdxW          = (NumIn > 1) ? $clog2(NumIn) : 1,
  localparam int unsigned PtrW          = $clog2(MaxOutstanding),
  localparam int unsigned CntW          = PtrW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  req_t             req_i [NumIn],
  input  logic [NumIn-1:0] req_valid_i,
  output logic [NumIn-1:0] req_ready_o,
  output resp_t            resp_o,
  output logic [NumIn-1:0] resp_valid_o,
  input  logic [NumIn-1:0] resp_ready_i,
  output req_t             link_req_o,
  output logic             link_req_valid_o,
  input  logic             link_req_ready_i,
  input  resp_t            link_resp_i,
  input  logic             link_resp_valid_i,
  output logic             link_resp_ready_o,
  output logic [CntW-1:0]  outstanding_o,
  output logic             busy_o
);

  // Padding to a power of two lets an index select a bit without going out of range.
  localparam int unsigned NumPad = 1 << IdxW;

  typedef logic [IdxW-1:0] idx_t;
  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  idx_t rr_q, rr_d;
  logic lock_q, lock_d;
  idx_t lock_idx_q, lock_idx_d;
  idx_t fifo_q [MaxOutstanding];
  ptr_t wr_ptr_q, rd_ptr_q;
  cnt_t cnt_q, cnt_d;

  logic [NumPad-1:0] valid_pad_s;
  logic [NumPad-1:0] ready_pad_s;
  idx_t              sel_idx_s;
  logic              sel_valid_s;
  logic              full_s;
  logic              empty_s;
  logic              push_s;
  logic              pop_s;
  idx_t              head_s;

  // Widen the requester valid and response-ready vectors to the padded width.
  always_comb begin
    valid_pad_s              = {NumPad{1'b0}};
    ready_pad_s              = {NumPad{1'b0}};
    valid_pad_s[NumIn-1:0]   = req_valid_i;
    ready_pad_s[NumIn-1:0]   = resp_ready_i;
  end

  // Choose the requester: the locked one, or else the first valid one from rr_q with wrap-around.
  always_comb begin
    int unsigned cand;
    cand      = 0;
    sel_idx_s = rr_q;
    if (lock_q) begin
      sel_idx_s = lock_idx_q;
    end else begin
      // Walk the offsets from highest to lowest, so the closest valid requester wins.
      for (int unsigned k = NumIn; k > 0; k--) begin
        cand = 32'(rr_q) + (k - 1);
        if (cand >= NumIn) begin
          cand = cand - NumIn;
        end else begin
          cand = cand;
        end
        if (valid_pad_s[idx_t'(cand)]) begin
          sel_idx_s = idx_t'(cand);
        end else begin
          sel_idx_s = sel_idx_s;
        end
      end
    end
    sel_valid_s = valid_pad_s[sel_idx_s];
  end

  // Request path: forward the selected payload and steer the link ready back to it.
  always_comb begin
    full_s           = (cnt_q == cnt_t'(MaxOutstanding));
    link_req_valid_o = sel_valid_s && !full_s;
    link_req_o       = req_i[0];
    req_ready_o      = {NumIn{1'b0}};
    for (int unsigned k = 0; k < NumIn; k++) begin
      if (idx_t'(k) == sel_idx_s) begin
        link_req_o     = req_i[k];
        req_ready_o[k] = link_req_valid_o && link_req_ready_i;
      end else begin
        req_ready_o[k] = 1'b0;
      end
    end
    push_s = link_req_valid_o && link_req_ready_i;
  end

  // Response path: the FIFO head selects which requester sees the link response.
  always_comb begin
    empty_s           = (cnt_q == cnt_t'(0));
    head_s            = fifo_q[rd_ptr_q];
    resp_o            = link_resp_i;
    resp_valid_o      = {NumIn{1'b0}};
    link_resp_ready_o = 1'b0;
    if (!empty_s) begin
      link_resp_ready_o = ready_pad_s[head_s];
      for (int unsigned k = 0; k < NumIn; k++) begin
        resp_valid_o[k] = link_resp_valid_i && (head_s == idx_t'(k));
      end
    end else begin
      link_resp_ready_o = 1'b0;
    end
    pop_s = link_resp_valid_i && link_resp_ready_o;
  end

  // Next-state logic for the round-robin pointer, the grant lock and the occupancy count.
  always_comb begin
    rr_d       = rr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    cnt_d      = cnt_q;
    if (push_s) begin
      lock_d = 1'b0;
      if (sel_idx_s == idx_t'(NumIn - 1)) begin
        rr_d = idx_t'(0);
      end else begin
        rr_d = sel_idx_s + idx_t'(1);
      end
    end else if (link_req_valid_o) begin
      lock_d     = 1'b1;
      lock_idx_d = sel_idx_s;
    end else begin
      lock_d = lock_q;
    end
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + cnt_t'(1);
      2'b01:   cnt_d = cnt_q - cnt_t'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers and ID FIFO storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= idx_t'(0);
      lock_q     <= 1'b0;
      lock_idx_q <= idx_t'(0);
      wr_ptr_q   <= ptr_t'(0);
      rd_ptr_q   <= ptr_t'(0);
      cnt_q      <= cnt_t'(0);
      for (int unsigned i = 0; i < MaxOutstanding; i++) begin
        fifo_q[i] <= idx_t'(0);
      end
    end else begin
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      cnt_q      <= cnt_d;
      if (push_s) begin
        fifo_q[wr_ptr_q] <= sel_idx_s;
        wr_ptr_q         <= wr_ptr_q + ptr_t'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + ptr_t'(1);
      end
    end
  end

  assign outstanding_o = cnt_q;
  assign busy_o        = (cnt_q != cnt_t'(0)) || link_req_valid_o;

  mempool_remote_link_arbiter_checker u_checker (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .lock_q_i         (lock_q),
    .lock_req_valid_i (valid_pad_s[lock_idx_q]),
    .link_resp_valid_i(link_resp_valid_i),
    .fifo_empty_i     (empty_s)
  );

endmodule
